// File: rtl/stream_arbiter_pkg.sv
// stream_arbiter_pkg: shared state type and default parameters for the stream arbiter.
package stream_arbiter_pkg;
    typedef enum logic {IDLE, LOCKED} arb_state_e;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_TIMEOUT    = 255;
endpackage

// File: rtl/stream_arbiter_if.sv
// stream_arbiter_if: requester-side and downstream stream signals of the arbiter.
interface stream_arbiter_if import stream_arbiter_pkg::*; #(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_last;
    logic                          out_ready;
    logic [NUM_REQ-1:0]            grant;
    logic                          timeout_err;
    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, grant, timeout_err
    );
    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, grant, timeout_err
    );
endinterface

// File: rtl/stream_arbiter_rr_pick.sv
// rr_pick: round-robin priority encoder searching upward from last_i+1 with wrap.
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [IW-1:0]      idx_o
);
    logic [IW-1:0] j;
    // Scan farthest-first so the nearest asserted requester overwrites the result.
    always_comb begin
        idx_o = '0;
        j = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = IW'((int'(last_i) + k) % NUM_REQ);
            idx_o = req_i[j] ? j : idx_o;
        end
    end
    assign pick_o = (|req_i) ? NUM_REQ'(1) << idx_o : '0;
endmodule

// File: rtl/stream_arbiter.sv
// stream_arbiter: packet-locked round-robin arbiter with a stall watchdog,
// muxing NUM_REQ upstream streams onto one downstream stream.
module stream_arbiter import stream_arbiter_pkg::*; #(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input logic clk,
    input logic reset,
    stream_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = $clog2(TIMEOUT + 1);
    arb_state_e            state_q;
    logic [NUM_REQ-1:0]    grant_q;
    logic [IW-1:0]         idx_q;
    logic [IW-1:0]         last_q;
    logic [SW-1:0]         stall_q;
    logic [SW-1:0]         stall_d;
    logic                  timeout_err_q;
    logic [NUM_REQ-1:0]    pick;
    logic [IW-1:0]         pick_idx;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] data_mux;
    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i (bus.req_valid),
        .last_i(last_q),
        .pick_o(pick),
        .idx_o (pick_idx)
    );
    // grant_q is zero outside LOCKED, so every downstream output is zero when idle.
    assign sel_valid       = |(bus.req_valid & grant_q);
    assign sel_last        = |(bus.req_last & grant_q);
    assign stall_d         = stall_q + SW'(1);
    assign bus.req_ready   = bus.out_ready ? grant_q : '0;
    assign bus.out_valid   = sel_valid;
    assign bus.out_last    = sel_last;
    assign bus.out_data    = data_mux;
    assign bus.grant       = grant_q;
    assign bus.timeout_err = timeout_err_q;
    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NUM_REQ; i++)
            data_mux = data_mux | (grant_q[i] ? bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] : '0);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            idx_q         <= '0;
            last_q        <= IW'(NUM_REQ - 1);
            stall_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: if (|bus.req_valid) begin
                    state_q <= LOCKED;
                    grant_q <= pick;
                    idx_q   <= pick_idx;
                    stall_q <= '0;
                end
                LOCKED: if (sel_valid) begin
                    stall_q <= '0;
                    if (bus.out_ready && sel_last) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        last_q  <= idx_q;
                    end
                end else begin
                    stall_q <= stall_d;
                    if (stall_d == SW'(TIMEOUT)) begin
                        state_q       <= IDLE;
                        grant_q       <= '0;
                        last_q        <= idx_q;
                        timeout_err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_stream_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    always #5 clk = ~clk;
    stream_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();
    stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b0;
        bus.req_valid = '0;
        bus.req_last = '0;
        bus.req_data = '0;
        bus.out_ready = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
    endtask
    task automatic test_reset();
        reset = 1'b0;
        bus.req_valid = '1;
        bus.req_last = '1;
        bus.req_data = '1;
        bus.out_ready = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({bus.grant, bus.req_ready, bus.out_valid, bus.out_last, bus.timeout_err} !== '0)
            $display("FAIL reset_ctrl: got grant=%b ready=%b ov=%b ol=%b te=%b, expected all zero",
                     bus.grant, bus.req_ready, bus.out_valid, bus.out_last, bus.timeout_err);
        vectors++;
        if (bus.out_data !== '0)
            $display("FAIL reset_data: got %h expected 0", bus.out_data);
        if (bus.out_data !== '0) miscompares++;
        if ({bus.grant, bus.req_ready, bus.out_valid, bus.out_last, bus.timeout_err} !== '0) miscompares++;
    endtask
    task automatic test_single_packet();
        logic [W-1:0] beats [3];
        for (int i = 0; i < 3; i++) beats[i] = $urandom;
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_data[0 +: W] = beats[0];
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL sp_idle_grant: got %b expected 0000", bus.grant);
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            bus.req_data[0 +: W] = beats[i];
            bus.req_last[0] = (i == 2);
            @(negedge clk);
            vectors++;
            if ({bus.grant, bus.out_valid, bus.req_ready} !== {4'b0001, 1'b1, 4'b0001}) begin
                miscompares++;
                $display("FAIL sp_lock beat%0d: got grant=%b ov=%b ready=%b expected 0001/1/0001",
                         i, bus.grant, bus.out_valid, bus.req_ready);
            end
            vectors++;
            if (bus.out_data !== beats[i] || bus.out_last !== (i == 2)) begin
                miscompares++;
                $display("FAIL sp_data beat%0d: got %h/%b expected %h/%b",
                         i, bus.out_data, bus.out_last, beats[i], i == 2);
            end
            next_cycle();
        end
        bus.req_valid = '0;
        bus.req_last = '0;
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0000 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sp_release: got grant=%b ov=%b expected 0000/0", bus.grant, bus.out_valid);
        end
        next_cycle();
    endtask
    task automatic test_round_robin();
        logic [N-1:0] e;
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_valid = '1;
        bus.req_last = '1;
        for (int r = 0; r < N; r++) bus.req_data[r*W +: W] = 32'hA000_0000 + r;
        for (int k = 0; k < 10; k++) begin
            e = (k % 2 == 1) ? N'(1) << ((k / 2) % N) : '0;
            @(negedge clk);
            vectors++;
            if (bus.grant !== e) begin
                miscompares++;
                $display("FAIL rr_grant cycle%0d: got %b expected %b", k, bus.grant, e);
            end
            if (k % 2 == 1) begin
                vectors++;
                if (bus.out_data !== 32'hA000_0000 + W'((k / 2) % N)) begin
                    miscompares++;
                    $display("FAIL rr_data cycle%0d: got %h expected %h",
                             k, bus.out_data, 32'hA000_0000 + (k / 2) % N);
                end
            end
            next_cycle();
        end
    endtask
    task automatic test_backpressure();
        logic [W-1:0] held;
        held = $urandom;
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0100;
        bus.req_data[2*W +: W] = ~held;
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0100) begin
            miscompares++;
            $display("FAIL bp_grant: got %b expected 0100", bus.grant);
        end
        next_cycle();
        bus.req_data[2*W +: W] = held;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if ({bus.grant, bus.timeout_err, bus.req_ready, bus.out_valid} !== {4'b0100, 1'b0, 4'b0000, 1'b1}
                || bus.out_data !== held) begin
                miscompares++;
                $display("FAIL bp_hold cycle%0d: got grant=%b te=%b ready=%b ov=%b data=%h expected 0100/0/0000/1/%h",
                         k, bus.grant, bus.timeout_err, bus.req_ready, bus.out_valid, bus.out_data, held);
            end
            next_cycle();
        end
        bus.out_ready = 1'b1;
        bus.req_last[2] = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 4'b0100 || bus.out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_last: got ready=%b ol=%b expected 0100/1", bus.req_ready, bus.out_last);
        end
        next_cycle();
        bus.req_valid = '0;
        bus.req_last = '0;
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0000 || bus.timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got grant=%b te=%b expected 0000/0", bus.grant, bus.timeout_err);
        end
        next_cycle();
    endtask
    task automatic test_timeout();
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0010;
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0010) begin
            miscompares++;
            $display("FAIL to_grant: got %b expected 0010", bus.grant);
        end
        next_cycle();
        bus.req_valid = '0;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.grant !== 4'b0010 || bus.timeout_err !== 1'b0 || bus.out_last !== 1'b0) begin
                miscompares++;
                $display("FAIL to_stall%0d: got grant=%b te=%b ol=%b expected 0010/0/0",
                         k, bus.grant, bus.timeout_err, bus.out_last);
            end
            next_cycle();
        end
        bus.req_valid = '1;
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0000 || bus.timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL to_pulse: got grant=%b te=%b expected 0000/1", bus.grant, bus.timeout_err);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0100 || bus.timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL to_next: got grant=%b te=%b expected 0100/0", bus.grant, bus.timeout_err);
        end
        next_cycle();
    endtask
    task automatic test_reset_mid_packet();
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b1000;
        bus.req_data[3*W +: W] = $urandom;
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b1000) begin
            miscompares++;
            $display("FAIL rm_grant: got %b expected 1000", bus.grant);
        end
        next_cycle();
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus.grant, bus.req_ready, bus.out_valid} !== '0 || bus.out_data !== '0) begin
            miscompares++;
            $display("FAIL rm_drop: got grant=%b ready=%b ov=%b data=%h expected zeros",
                     bus.grant, bus.req_ready, bus.out_valid, bus.out_data);
        end
        next_cycle();
        bus.req_valid = '1;
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL rm_idle: got %b expected 0000", bus.grant);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL rm_first: got %b expected 0001", bus.grant);
        end
        next_cycle();
    endtask
    task automatic test_blocked_requester();
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0010;
        next_cycle();
        bus.req_valid = 4'b0011;
        for (int b = 0; b < 3; b++) begin
            bus.req_last[1] = (b == 2);
            @(negedge clk);
            vectors++;
            if (bus.grant !== 4'b0010 || bus.req_ready[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL bl_beat%0d: got grant=%b ready=%b expected 0010/0010", b, bus.grant, bus.req_ready);
            end
            next_cycle();
        end
        bus.req_valid = 4'b0001;
        bus.req_last = '0;
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0000 || bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL bl_bubble: got grant=%b ready=%b expected 0000/0000", bus.grant, bus.req_ready);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL bl_next: got %b expected 0001", bus.grant);
        end
        next_cycle();
    endtask
    // Model: owner is the locked requester (-1 when idle); priority rotates from last_owner+1.
    task automatic test_random();
        int owner, last_owner, stall, quiet;
        logic te;
        logic [N-1:0] v, l, e_grant, e_ready;
        logic [W-1:0] d [N];
        logic rdy, e_ov, e_ol;
        logic [W-1:0] e_od;
        do_reset();
        owner = -1;
        last_owner = N - 1;
        stall = 0;
        quiet = 0;
        te = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (quiet > 0) quiet--;
            else if ($urandom_range(0, 19) == 0) quiet = 6;
            for (int r = 0; r < N; r++) begin
                v[r] = (quiet == 0) && ($urandom_range(0, 9) < 7);
                l[r] = ($urandom_range(0, 3) == 0);
                d[r] = $urandom;
                bus.req_data[r*W +: W] = d[r];
            end
            rdy = ($urandom_range(0, 3) != 0);
            bus.req_valid = v;
            bus.req_last = l;
            bus.out_ready = rdy;
            e_grant = (owner < 0) ? '0 : N'(1) << owner;
            e_ready = rdy ? e_grant : '0;
            e_ov = (owner >= 0) && v[owner];
            e_ol = (owner >= 0) && l[owner];
            e_od = (owner >= 0) ? d[owner] : '0;
            @(negedge clk);
            vectors++;
            if ({bus.grant, bus.req_ready, bus.out_valid, bus.out_last, bus.timeout_err}
                !== {e_grant, e_ready, e_ov, e_ol, te}) begin
                miscompares++;
                $display("FAIL rnd_ctrl cycle%0d: got g=%b r=%b ov=%b ol=%b te=%b expected g=%b r=%b ov=%b ol=%b te=%b",
                         c, bus.grant, bus.req_ready, bus.out_valid, bus.out_last, bus.timeout_err,
                         e_grant, e_ready, e_ov, e_ol, te);
            end
            vectors++;
            if (bus.out_data !== e_od) begin
                miscompares++;
                $display("FAIL rnd_data cycle%0d: got %h expected %h", c, bus.out_data, e_od);
            end
            te = 1'b0;
            if (owner < 0) begin
                for (int k = N; k >= 1; k--)
                    if (v[(last_owner + k) % N]) owner = (last_owner + k) % N;
                stall = 0;
            end else if (v[owner]) begin
                stall = 0;
                if (rdy && l[owner]) begin
                    last_owner = owner;
                    owner = -1;
                end
            end else begin
                stall++;
                if (stall == TO) begin
                    last_owner = owner;
                    owner = -1;
                    te = 1'b1;
                end
            end
            next_cycle();
        end
    endtask
    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid_packet();
        test_blocked_requester();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stream_arbiter.md
# stream_arbiter

Round-robin, packet-locked arbiter that shares one downstream stream port (the `stream_in` port of `my_module`) between `NUM_REQ` upstream requesters. Each requester presents a valid/ready/last stream of `DATA_WIDTH` bits. The arbiter grants one requester per packet and holds the grant until that packet's last beat. A stall watchdog releases the grant if the granted requester stops supplying data mid-packet.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `DATA_WIDTH`, default 64: stream data width in bits.
- `TIMEOUT`, default 255: consecutive stalled cycles (granted `req_valid` low while locked) before forced release; ≥1.

- `clk` input 1: single clock, all logic rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input NUM_REQ: per-requester valid.
- `req_data` input NUM_REQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last` input NUM_REQ: per-requester end-of-packet.
- `req_ready` output NUM_REQ: per-requester ready.
- `out_valid` output 1: downstream valid.
- `out_data` output DATA_WIDTH: downstream data.
- `out_last` output 1: downstream end-of-packet.
- `out_ready` input 1: downstream ready.
- `grant` output NUM_REQ: one-hot current grant; all-zero when idle.
- `timeout_err` output 1: one-cycle pulse on watchdog release.

## Operation
- Transfer rule: a beat transfers on a cycle where valid and ready are both high. This applies upstream and downstream.
- FSM states: IDLE and LOCKED.
- IDLE:
  - `grant`, `req_ready` and `out_valid` are 0.
  - If any `req_valid` is high, pick the first asserted requester searching from (`last_grant`+1) mod NUM_REQ upward with wrap.
  - Register that pick into `grant` and go to LOCKED.
- LOCKED, granted index g:
  - Combinational pass-through: `out_valid`=`req_valid[g]`, `out_data`=`req_data[g]`, `out_last`=`req_last[g]`, `req_ready[g]`=`out_ready`.
  - All other `req_ready` bits are 0.
- Release on transfer with `req_last[g]`=1:
  - Next state IDLE, `last_grant`<=g, `grant`<=0.
- Watchdog:
  - `stall_cnt` increments each LOCKED cycle with `req_valid[g]`=0.
  - It clears on any cycle with `req_valid[g]`=1, and on entry to LOCKED.
  - When `stall_cnt` reaches TIMEOUT: next state IDLE, `last_grant`<=g, `timeout_err` high for exactly the following cycle.
  - Downstream sees a truncated packet (no `out_last`). This is accepted and is the consumer's responsibility.
- Backpressure (`out_ready`=0 with `req_valid[g]`=1) is not a stall and never triggers the watchdog.
- Single-beat packet (`req_last` on first beat) releases after one transfer.
- `req_valid` deasserting on non-granted requesters has no effect.

## Timing
- Reset values (asynchronous, `reset`=0): state IDLE, `grant`=0, `last_grant`=NUM_REQ-1 so requester 0 has first priority, `stall_cnt`=0, `timeout_err`=0.
- Outputs during reset: `req_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
- Reset mid-packet drops the grant immediately. No completion is owed to either side.
- Arbitration latency: 1 cycle.
  - A request seen in IDLE at cycle n gives `grant` valid and the first possible transfer at cycle n+1.
- Back-to-back packets:
  - Last beat at cycle n, IDLE at n+1, next grant at n+2, next transfer at n+2.
  - This is one bubble cycle per packet.
- Data path adds zero latency while LOCKED: `out_*` and `req_ready` are combinational from inputs and the registered `grant`.
- Simultaneous last beat and watchdog terminal count cannot coincide, because a transfer requires valid=1, which clears `stall_cnt`.
- `stall_cnt` width: $clog2(TIMEOUT+1); it never wraps.

## Structure
- `stream_arbiter_pkg`: state enum `arb_state_e` {IDLE, LOCKED}, and default parameter constants.
- Sub-module `rr_pick`: combinational round-robin priority encoder.
  - Inputs: request vector, `last_grant` index.
  - Output: one-hot pick and its index.
  - Parameterised by NUM_REQ.
- The FSM, watchdog and data mux live in `stream_arbiter`.

## Test plan
- Reset then `req_valid`=4'b0001, 3-beat packet, `out_ready`=1 → `grant`=0001 one cycle after request; `out_data` equals the 3 beats in order; IDLE after the last beat.
- All four requesters hold valid with 1-beat packets → grants cycle 0,1,2,3,0, each with one bubble cycle between.
- Requester 2 locked, `out_ready` low 10 cycles mid-packet → no grant change, `timeout_err` stays 0, data held stable.
- TIMEOUT=4, requester 1 locked, drops `req_valid` after beat 1 → `timeout_err` pulses on the cycle after `stall_cnt` reaches 4; `grant`=0; next arbitration starts from requester 2.
- `reset` asserted mid-packet while requester 3 is locked → `grant`, `req_ready` and `out_valid` go to 0 immediately; after release requester 0 wins first.
- Requester 0 `req_valid` high but not granted while requester 1 is locked → `req_ready[0]`=0 throughout; requester 0 granted after requester 1's last beat.
